// File: rtl/de0_cv_pkg.sv
// ============================================================================
// Package : de0_cv_pkg
// Purpose : Shared constants and types for the DE0-CV SPI pattern generator.
//           Holds the register map, the decoded SPI command header and a
//           helper that classifies an address as register or FIFO space.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package de0_cv_pkg;

  // Register map
  localparam logic [7:0] ADDR_CTRL      = 8'h00;  // bit0 = start_pg
  localparam logic [7:0] ADDR_SPEED     = 8'h7F;  // clocks per pattern word
  localparam logic [7:0] ADDR_FIFO_BASE = 8'h80;  // 0x80..0xFF = pattern FIFO

  // Header direction bit
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Decoded frame header
  typedef struct packed {
    logic [7:0] addr;
    logic       rw;
  } spi_cmd_t;

  // The upper half of the address space maps onto the FIFO
  function automatic logic is_fifo_addr(input logic [7:0] a);
    return a >= ADDR_FIFO_BASE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/de0_cv_spi_slave.sv
// ============================================================================
// Module  : spi_slave
// Purpose : SPI mode-0 slave, MSB first, 32-bit frames, oversampled in the
//           system clock domain. Header = addr[7:0], rw, 7 ignored bits;
//           followed by DATA_W data bits.
// Ports   : clk, rst_n            system clock, async active-low reset
//           sclk_pin/ssn_pin/mosi_pin  raw SPI pins (asynchronous)
//           miso                  serial read data (0 when idle)
//           wr_en                 1-clk pulse, write data complete
//           rd_req                1-clk pulse, read header complete
//           addr                  frame address (valid from header onward)
//           wdata                 write data (valid with wr_en)
//           rdata                 read data, sampled in the rd_req cycle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave
  import de0_cv_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_pin,
  input  logic              ssn_pin,
  input  logic              mosi_pin,
  output logic              miso,
  output logic              wr_en,
  output logic              rd_req,
  output logic [7:0]        addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  localparam int HDR_BITS   = 16;
  localparam int FRAME_BITS = HDR_BITS + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ssn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      rx_sh;
  logic [DATA_W-1:0]      tx_sh;
  spi_cmd_t               cmd;

  logic sclk_s, ssn_s, mosi_s, sclk_rise;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ssn_sync  <= '1;            // bus idles deselected
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      cmd       <= '0;
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;
      wdata     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
      sclk_prev <= sclk_s;
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;

      if (ssn_s) begin
        // Deselect (including a mid-frame abort) discards the frame
        bit_cnt <= '0;
        tx_sh   <= '0;
      end else begin
        if (sclk_rise && bit_cnt < CNT_W'(FRAME_BITS)) begin
          rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s};
          bit_cnt <= bit_cnt + 1'b1;
          // 16th rise: the incoming bit completes the header, so the
          // header fields sit one position lower in the pre-shift register
          if (bit_cnt == CNT_W'(HDR_BITS - 1)) begin
            cmd.addr <= rx_sh[14:7];
            cmd.rw   <= rx_sh[6];
            rd_req   <= (rx_sh[6] == RW_READ);
          end
          if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            wr_en <= (cmd.rw == RW_WRITE);
            wdata <= {rx_sh[DATA_W-2:0], mosi_s};
          end
          // Master has sampled miso on this rise; present the next bit
          if (bit_cnt >= CNT_W'(HDR_BITS))
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
        end
        if (rd_req)
          tx_sh <= rdata;
      end
    end
  end

  assign miso = tx_sh[DATA_W-1];
  assign addr = cmd.addr;

endmodule

`default_nettype wire

// File: rtl/de0_cv.sv
// ============================================================================
// Module  : de0_cv
// Purpose : DE0-CV board top. SPI slave on GPIO_0 gives access to a 128-entry
//           register file and a pattern FIFO; a pattern generator streams
//           FIFO words onto GPIO_1 at a programmable rate.
// Ports   : CLOCK_50           system clock (sole clock)
//           RESET_N            async active-low reset
//           CLOCK2/3/4_50, KEY, SW   unused
//           HEX0..HEX5         all segments off
//           LEDR               [0]=start_pg [1]=fifo_empty [2]=fifo_full
//                              [3]=pg_valid
//           SD_CLK/SD_CMD/SD_DATA    idle (0 / high-Z)
//           GPIO_0             [0]=mosi [1]=sclk [2]=ssn [3]=miso
//           GPIO_1             [15:0]=pattern [16]=pg_valid
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module de0_cv
  import de0_cv_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK_50,
  input  logic        CLOCK2_50,
  input  logic        CLOCK3_50,
  input  logic        CLOCK4_50,
  input  logic        RESET_N,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [9:0]  LEDR,
  output logic        SD_CLK,
  inout  wire         SD_CMD,
  inout  wire  [3:0]  SD_DATA,
  inout  wire  [35:0] GPIO_0,
  inout  wire  [35:0] GPIO_1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic clk, rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = RESET_N;

  // SPI side
  logic              miso, spi_wr_en, spi_rd_req;
  logic [7:0]        spi_addr;
  logic [DATA_W-1:0] spi_wdata, spi_rdata;

  // Storage
  logic [DATA_W-1:0] regs     [128];
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;    // extra MSB distinguishes full/empty

  // Pattern generator
  logic [DATA_W-1:0] pattern, pg_cnt, pg_speed, pg_limit, fifo_head;
  logic              pg_valid, start_pg, pg_tick;
  logic              fifo_empty, fifo_full, spi_is_fifo;
  logic              push, spi_pop, pg_pop, pop;

  spi_slave #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_spi (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk_pin (GPIO_0[1]),
    .ssn_pin  (GPIO_0[2]),
    .mosi_pin (GPIO_0[0]),
    .miso     (miso),
    .wr_en    (spi_wr_en),
    .rd_req   (spi_rd_req),
    .addr     (spi_addr),
    .wdata    (spi_wdata),
    .rdata    (spi_rdata)
  );

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_head   = fifo_empty ? '0 : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign spi_is_fifo = is_fifo_addr(spi_addr);

  assign start_pg = regs[7'(ADDR_CTRL)][0];
  assign pg_speed = regs[7'(ADDR_SPEED)];
  assign pg_limit = (pg_speed == '0) ? DATA_W'(1) : pg_speed;
  // >= keeps the counter from running away if the rate is lowered mid-count
  assign pg_tick  = start_pg && (pg_cnt >= pg_limit - 1'b1);

  // A PG pop and an SPI pop in the same clk share one pointer advance; the
  // SPI read still returns fifo_head, i.e. the same word the PG took.
  assign push    = spi_wr_en & spi_is_fifo & ~fifo_full;
  assign spi_pop = spi_rd_req & spi_is_fifo & ~fifo_empty;
  assign pg_pop  = pg_tick & ~fifo_empty;
  assign pop     = spi_pop | pg_pop;

  assign spi_rdata = spi_is_fifo ? fifo_head : regs[spi_addr[6:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++)
        regs[i] <= '0;
    end else if (spi_wr_en && !spi_is_fifo) begin
      regs[spi_addr[6:0]] <= spi_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= spi_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_cnt   <= '0;
      pg_valid <= 1'b0;
      pattern  <= '0;
    end else if (!start_pg) begin
      pg_cnt   <= '0;
      pg_valid <= 1'b0;
    end else if (pg_tick) begin
      pg_cnt   <= '0;
      pg_valid <= ~fifo_empty;
      if (!fifo_empty)
        pattern <= fifo_head;
    end else begin
      pg_cnt <= pg_cnt + 1'b1;
    end
  end

  // Board outputs
  assign HEX0   = 7'h7F;
  assign HEX1   = 7'h7F;
  assign HEX2   = 7'h7F;
  assign HEX3   = 7'h7F;
  assign HEX4   = 7'h7F;
  assign HEX5   = 7'h7F;
  assign LEDR   = {6'b0, pg_valid, fifo_full, fifo_empty, start_pg};
  assign SD_CLK = 1'b0;
  assign SD_CMD  = 1'bz;
  assign SD_DATA = 4'bzzzz;

  assign GPIO_0[3]     = miso;
  assign GPIO_0[35:4]  = {32{1'bz}};
  assign GPIO_1[15:0]  = pattern;
  assign GPIO_1[16]    = pg_valid;
  assign GPIO_1[35:17] = {19{1'bz}};

  wire unused_pins = &{1'b0, CLOCK2_50, CLOCK3_50, CLOCK4_50, KEY, SW,
                       SD_CMD, SD_DATA, GPIO_0[35:3], GPIO_1};

endmodule

`default_nettype wire

// File: tb/tb_de0_cv.sv
// ============================================================================
// Module  : tb_de0_cv
// Purpose : Self-checking bench for de0_cv. Drives SPI frames on GPIO_0 and
//           scoreboards SPI read data and pattern-generator output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_de0_cv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic ssn = 1'b1;
  logic mosi = 1'b0;

  wire [35:0] gpio0;
  wire [35:0] gpio1;
  wire        sd_cmd;
  wire [3:0]  sd_data;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [9:0] ledr;
  logic       sd_clk;

  assign gpio0[2:0] = {ssn, sclk, mosi};

  always #10 clk = ~clk;

  de0_cv dut (
    .CLOCK_50  (clk),
    .CLOCK2_50 (1'b0),
    .CLOCK3_50 (1'b0),
    .CLOCK4_50 (1'b0),
    .RESET_N   (rst_n),
    .KEY       (4'b0),
    .SW        (10'b0),
    .HEX0      (hex0),
    .HEX1      (hex1),
    .HEX2      (hex2),
    .HEX3      (hex3),
    .HEX4      (hex4),
    .HEX5      (hex5),
    .LEDR      (ledr),
    .SD_CLK    (sd_clk),
    .SD_CMD    (sd_cmd),
    .SD_DATA   (sd_data),
    .GPIO_0    (gpio0),
    .GPIO_1    (gpio1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [15:0] val; string name; } rd_exp_t;
  typedef struct { logic [15:0] word; int gap; } pg_exp_t;

  rd_exp_t rd_q[$];
  pg_exp_t pg_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One SPI frame; nbits < 32 models an aborted frame
  task automatic spi_frame(input logic [7:0] a, input logic rw, input logic [15:0] d, input int nbits);
    logic [31:0] f;
    f = {a, rw, 7'b0, d};
    @(posedge clk);
    #3;
    ssn = 1'b0;
    #50;
    for (int i = 31; i >= 32 - nbits; i--) begin
      mosi = f[i];
      #50;
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
    #50;
    ssn  = 1'b1;
    mosi = 1'b0;
    #300;
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [15:0] d);
    spi_frame(a, 1'b0, d, 32);
  endtask

  task automatic spi_read(input logic [7:0] a, input logic [15:0] exp, input string name);
    rd_exp_t e;
    e.val  = exp;
    e.name = name;
    rd_q.push_back(e);
    spi_frame(a, 1'b1, 16'h0000, 32);
  endtask

  task automatic pg_expect(input logic [15:0] w, input int gap);
    pg_exp_t e;
    e.word = w;
    e.gap  = gap;
    pg_q.push_back(e);
  endtask

  task automatic wait_pg_drained(input string name);
    for (int i = 0; i < 3000 && pg_q.size() != 0; i++)
      @(posedge clk);
    checks++;
    if (pg_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d pattern words still expected, required 0", name, pg_q.size());
      pg_q.delete();
    end
  endtask

  // SPI read monitor: reassembles frames from the pins
  initial begin
    int          bits;
    logic [15:0] hdr, rdw;
    rd_exp_t     e;
    forever begin
      @(negedge ssn);
      bits = 0;
      hdr  = '0;
      rdw  = '0;
      while (1) begin
        @(posedge sclk or posedge ssn);
        if (ssn) break;
        if (bits < 16) hdr = {hdr[14:0], mosi};
        else           rdw = {rdw[14:0], gpio0[3]};
        bits++;
      end
      if (bits == 32 && hdr[7]) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_unexpected_read actual=%h expected=none", rdw);
        end else begin
          e = rd_q.pop_front();
          check(e.name, {16'h0, rdw}, {16'h0, e.val});
        end
      end
    end
  end

  // Pattern monitor: each new valid word is one PG emission
  initial begin
    int          since = 0;
    logic [15:0] last = 16'h0000;
    pg_exp_t     e;
    forever begin
      @(negedge clk);
      since++;
      if (gpio1[16] && gpio1[15:0] !== last) begin
        if (pg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pg_unexpected_word actual=%h expected=none", gpio1[15:0]);
        end else begin
          e = pg_q.pop_front();
          check("pg_word", {16'h0, gpio1[15:0]}, {16'h0, e.word});
          if (e.gap != 0)
            check("pg_spacing_clk", since, e.gap);
        end
        last  = gpio1[15:0];
        since = 0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1000;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ledr", {22'h0, ledr}, 32'h0000_0002);
    check("reset_miso", {31'h0, gpio0[3]}, 32'h0);
    check("reset_pattern", {15'h0, gpio1[16:0]}, 32'h0);
    check("reset_hex0", {25'h0, hex0}, 32'h7F);

    spi_read(8'h00, 16'h0000, "rd_ctrl_reset");
    spi_read(8'h7F, 16'h0000, "rd_speed_reset");

    // Stream f1..f4 at 10 clk per word
    pg_expect(16'h00f1, 0);
    pg_expect(16'h00f2, 10);
    pg_expect(16'h00f3, 10);
    pg_expect(16'h00f4, 10);
    spi_write(8'h80, 16'h00f1);
    spi_write(8'h80, 16'h00f2);
    spi_write(8'h80, 16'h00f3);
    spi_write(8'h80, 16'h00f4);
    spi_write(8'h7F, 16'h000A);
    spi_write(8'h00, 16'h0001);
    wait_pg_drained("pg_run1");
    repeat (15) @(posedge clk);
    #1;
    check("pg_hold_valid", {31'h0, gpio1[16]}, 32'h0);
    check("pg_hold_word", {16'h0, gpio1[15:0]}, 32'h00f4);
    check("led_running_empty", {22'h0, ledr}, 32'h0000_0003);

    // Stop, then stream f5..f8 at 5 clk per word
    spi_write(8'h00, 16'h0000);
    check("pg_stopped", {15'h0, gpio1[16:0]}, 32'h0000_00f4);
    pg_expect(16'h00f5, 0);
    pg_expect(16'h00f6, 5);
    pg_expect(16'h00f7, 5);
    pg_expect(16'h00f8, 5);
    spi_write(8'h80, 16'h00f5);
    spi_write(8'h80, 16'h00f6);
    spi_write(8'h80, 16'h00f7);
    spi_write(8'h80, 16'h00f8);
    spi_write(8'h7F, 16'h0005);
    spi_write(8'h00, 16'h0001);
    wait_pg_drained("pg_run2");
    spi_write(8'h00, 16'h0000);

    // SPI FIFO reads with PG stopped
    spi_write(8'h80, 16'h00f1);
    spi_write(8'h80, 16'h00f2);
    spi_read(8'h80, 16'h00f1, "fifo_rd1");
    spi_read(8'h80, 16'h00f2, "fifo_rd2");
    spi_read(8'h80, 16'h0000, "fifo_rd_empty");
    check("led_empty_after_reads", {22'h0, ledr}, 32'h0000_0002);

    // Fill to full; the 17th word must be dropped
    for (int i = 0; i < 16; i++)
      spi_write(8'h80 + 8'(i), 16'h0100 + 16'(i));
    check("led_full", {22'h0, ledr}, 32'h0000_0004);
    spi_write(8'h80, 16'hDEAD);
    check("led_full_after_drop", {22'h0, ledr}, 32'h0000_0004);
    for (int i = 0; i < 16; i++)
      spi_read(8'h80, 16'h0100 + 16'(i), $sformatf("fifo_fill_rd%0d", i));
    spi_read(8'h80, 16'h0000, "fifo_rd_after_drop");

    // Generic register and aborted frame
    spi_write(8'h05, 16'hBEEF);
    spi_read(8'h05, 16'hBEEF, "rd_reg05");
    spi_frame(8'h7F, 1'b0, 16'h1234, 10);
    spi_read(8'h7F, 16'h0005, "rd_speed_after_abort");
    spi_write(8'h7F, 16'h0033);
    spi_read(8'h7F, 16'h0033, "rd_speed_after_rewrite");
    spi_read(8'h00, 16'h0000, "rd_ctrl_final");

    repeat (20) @(posedge clk);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
